// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake; shifts by a variable amount and
// multiply run as iterative multi-cycle operations.
module alu_seq #(
    parameter int unsigned W   = 8,
    parameter int unsigned OPW = 4
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           Start,
    input  logic [OPW-1:0] OP,
    input  logic           Signed,
    input  logic [W-1:0]   InputA,
    input  logic [W-1:0]   InputB,
    output logic [W-1:0]   Out,
    output logic           Zero,
    output logic           Carry,
    output logic           Neg,
    output logic           Done,
    output logic           Busy
);

    localparam int unsigned SW = $clog2(W);
    localparam int unsigned CW = SW + 1;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_RXOR = OPW'(1);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(2);
    localparam logic [OPW-1:0] OP_AND  = OPW'(3);
    localparam logic [OPW-1:0] OP_LSH  = OPW'(4);
    localparam logic [OPW-1:0] OP_RSH  = OPW'(5);
    localparam logic [OPW-1:0] OP_SEQ  = OPW'(6);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(7);
    localparam logic [OPW-1:0] OP_OR   = OPW'(8);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(9);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(10);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MUL   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  work_q, work_d;
    logic          left_q, left_d;
    logic          arith_q, arith_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]  mplier_q, mplier_d;
    logic [W-1:0]  out_q, out_d;
    logic          zero_q, zero_d;
    logic          carry_q, carry_d;
    logic          neg_q, neg_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic [SW-1:0] shamt_c;
    logic [W-1:0]  sc_res_c;
    logic          sc_cry_c;
    logic [W:0]    add_c;
    logic [W-1:0]  acc_sum_c;
    logic [W-1:0]  fin_res_c;
    logic          fin_cry_c;
    logic          fin_c;

    // State and datapath registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            left_q   <= 1'b0;
            arith_q  <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            out_q    <= '0;
            zero_q   <= 1'b1;
            carry_q  <= 1'b0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            left_q   <= left_d;
            arith_q  <= arith_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            out_q    <= out_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Single-cycle result from the live operands (only used on accept)
    always_comb begin
        shamt_c  = InputB[SW-1:0];
        add_c    = {1'b0, InputA} + {1'b0, InputB};
        sc_res_c = '0;
        sc_cry_c = 1'b0;
        case (OP)
            OP_ADD: begin
                sc_res_c = add_c[W-1:0];
                sc_cry_c = add_c[W];
            end
            OP_RXOR: sc_res_c = {{(W-1){1'b0}}, ^InputA};
            OP_XOR:  sc_res_c = InputA ^ InputB;
            OP_AND:  sc_res_c = InputA & InputB;
            // Zero shift amount: operand passes through unchanged
            OP_LSH:  sc_res_c = InputA;
            OP_RSH:  sc_res_c = InputA;
            OP_SEQ:  sc_res_c = (InputA == InputB) ? '0 : W'(1);
            OP_SLT: begin
                if (Signed) sc_res_c = ($signed(InputA) < $signed(InputB)) ? '0 : W'(1);
                else        sc_res_c = (InputA < InputB) ? '0 : W'(1);
            end
            OP_OR:   sc_res_c = InputA | InputB;
            OP_SUB: begin
                sc_res_c = InputA - InputB;
                sc_cry_c = (InputA < InputB);
            end
            default: sc_res_c = '0;
        endcase
    end

    // Next-state, iteration and result registers
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        left_d    = left_q;
        arith_d   = arith_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        out_d     = out_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        neg_d     = neg_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        fin_c     = 1'b0;
        fin_res_c = '0;
        fin_cry_c = 1'b0;
        acc_sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if ((OP == OP_LSH || OP == OP_RSH) && shamt_c != '0) begin
                        work_d  = InputA;
                        cnt_d   = CW'(shamt_c);
                        left_d  = (OP == OP_LSH);
                        arith_d = (OP == OP_RSH) && Signed;
                        busy_d  = 1'b1;
                        state_d = S_SHIFT;
                    end else if (OP == OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = InputA;
                        mplier_d = InputB;
                        cnt_d    = CW'(W);
                        busy_d   = 1'b1;
                        state_d  = S_MUL;
                    end else begin
                        fin_c     = 1'b1;
                        fin_res_c = sc_res_c;
                        fin_cry_c = sc_cry_c;
                    end
                end
            end
            S_SHIFT: begin
                work_d = left_q ? {work_q[W-2:0], 1'b0}
                                : {arith_q & work_q[W-1], work_q[W-1:1]};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    fin_c     = 1'b1;
                    fin_res_c = work_d;
                end
            end
            S_MUL: begin
                acc_d    = acc_sum_c;
                mcand_d  = {mcand_q[W-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[W-1:1]};
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    fin_c     = 1'b1;
                    fin_res_c = acc_sum_c;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fin_c) begin
            out_d   = fin_res_c;
            zero_d  = (fin_res_c == '0);
            carry_d = fin_cry_c;
            neg_d   = fin_res_c[W-1];
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
        end
    end

    assign Out   = out_q;
    assign Zero  = zero_q;
    assign Carry = carry_q;
    assign Neg   = neg_q;
    assign Done  = done_q;
    assign Busy  = busy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=8) with an arithmetic reference model.
module tb_alu_seq;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Start;
    logic [3:0] OP;
    logic       Signed;
    logic [7:0] InputA;
    logic [7:0] InputB;
    logic [7:0] Out;
    logic       Zero;
    logic       Carry;
    logic       Neg;
    logic       Done;
    logic       Busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.W(8), .OPW(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .OP(OP), .Signed(Signed),
        .InputA(InputA), .InputB(InputB), .Out(Out), .Zero(Zero), .Carry(Carry),
        .Neg(Neg), .Done(Done), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // Reference: result, carry and number of edges after accept until Done
    task automatic model(input logic [3:0] op, input logic sgn, input logic [7:0] a,
                         input logic [7:0] b, output logic [7:0] r, output logic c,
                         output int lat);
        int s;
        int p;
        s   = int'(b) % 8;
        r   = 8'h00;
        c   = 1'b0;
        lat = 0;
        case (op)
            4'd0: begin p = int'(a) + int'(b); r = 8'(p); c = (p > 255); end
            4'd1: begin p = 0; for (int i = 0; i < 8; i++) p += int'(a[i]); r = 8'(p % 2); end
            4'd2: r = a ^ b;
            4'd3: r = a & b;
            4'd4: begin r = 8'((int'(a) * (1 << s)) % 256); lat = s; end
            4'd5: begin
                if (sgn) r = 8'($signed(a) >>> s);
                else     r = 8'(int'(a) / (1 << s));
                lat = s;
            end
            4'd6: r = (a == b) ? 8'd0 : 8'd1;
            4'd7: begin
                if (sgn) r = ($signed(a) < $signed(b)) ? 8'd0 : 8'd1;
                else     r = (int'(a) < int'(b)) ? 8'd0 : 8'd1;
            end
            4'd8: r = a | b;
            4'd9: begin p = int'(a) - int'(b); r = 8'(p + 256); c = (p < 0); end
            4'd10: begin p = int'(a) * int'(b); r = 8'(p % 256); lat = 8; end
            default: r = 8'h00;
        endcase
    endtask

    // Issue one op from idle, then wait (bounded) for Done
    task automatic run_op(input logic [3:0] op, input logic sgn, input logic [7:0] a,
                          input logic [7:0] b, output int edges, output int busy_n,
                          output bit out_moved, output bit timeout);
        logic [7:0] prev;
        prev   = Out;
        Start  = 1'b1; OP = op; Signed = sgn; InputA = a; InputB = b;
        @(posedge Clk); #1;
        Start  = 1'b0; OP = 4'($urandom); Signed = 1'($urandom);
        InputA = 8'($urandom); InputB = 8'($urandom);
        edges = 0; busy_n = 0; out_moved = 1'b0; timeout = 1'b0;
        while (Done !== 1'b1) begin
            if (Busy === 1'b1) busy_n++;
            if (Out !== prev) out_moved = 1'b1;
            if (edges >= 40) begin timeout = 1'b1; break; end
            @(posedge Clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; Start = 1'b0; OP = '0; Signed = 1'b0; InputA = '0; InputB = '0;
        repeat (3) @(posedge Clk);
        #1;
        n_checks++;
        if ({Out, Zero, Carry, Neg, Done, Busy} !== {8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got Out=%h Z=%b C=%b N=%b D=%b B=%b expected 00 1 0 0 0 0",
                     Out, Zero, Carry, Neg, Done, Busy);
        end
        Reset_n = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [7:0] r;
        logic       c;
        int         lat;
        logic [3:0] op;
        logic [7:0] a, b;
        Start = 1'b1; OP = 4'd0; Signed = 1'b0; InputA = 8'hF0; InputB = 8'h20;
        @(posedge Clk); #1;
        n_checks++;
        if ({Out, Carry, Neg, Done} !== {8'h10, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_add: got Out=%h C=%b N=%b D=%b expected 10 1 0 1", Out, Carry, Neg, Done);
        end
        OP = 4'd9; InputA = 8'h05; InputB = 8'h07;
        @(posedge Clk); #1;
        n_checks++;
        if ({Out, Carry, Neg, Done} !== {8'hFE, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_sub: got Out=%h C=%b N=%b D=%b expected FE 1 1 1", Out, Carry, Neg, Done);
        end
        // Random stream of single-cycle ops with Start held high
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
            if (op == 4'd10) op = 4'd2;
            if (op == 4'd4 || op == 4'd5) b[2:0] = 3'd0;
            Signed = 1'($urandom); OP = op; InputA = a; InputB = b;
            model(op, Signed, a, b, r, c, lat);
            @(posedge Clk); #1;
            n_checks++;
            if ({Out, Zero, Carry, Neg, Done, Busy} !== {r, r == 8'h00, c, r[7], 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL b2b_stream op=%0d: got Out=%h Z=%b C=%b N=%b D=%b B=%b expected %h %b %b %b 1 0",
                         op, Out, Zero, Carry, Neg, Done, Busy, r, r == 8'h00, c, r[7]);
            end
        end
        Start = 1'b0;
        @(posedge Clk); #1;
        n_checks++;
        if (Done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_drop: got Done=%b expected 0", Done);
        end
    endtask

    task automatic test_mul;
        logic [7:0] prev;
        prev = Out;
        Start = 1'b1; OP = 4'd10; Signed = 1'b0; InputA = 8'd13; InputB = 8'd11;
        @(posedge Clk); #1;
        Start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if ({Busy, Done, Out} !== {1'b1, 1'b0, prev}) begin
                n_fail++;
                $display("FAIL mul_busy k=%0d: got B=%b D=%b Out=%h expected 1 0 %h", k, Busy, Done, Out, prev);
            end
            if (k == 3) begin Start = 1'b1; OP = 4'd0; InputA = 8'd1; InputB = 8'd1; end
            else Start = 1'b0;
            @(posedge Clk); #1;
        end
        n_checks++;
        if ({Out, Zero, Carry, Neg, Done, Busy} !== {8'h8F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mul_done: got Out=%h Z=%b C=%b N=%b D=%b B=%b expected 8f 0 0 1 1 0",
                     Out, Zero, Carry, Neg, Done, Busy);
        end
        @(posedge Clk); #1;
        n_checks++;
        if ({Done, Busy, Out} !== {1'b0, 1'b0, 8'h8F}) begin
            n_fail++;
            $display("FAIL mul_after: got D=%b B=%b Out=%h expected 0 0 8f", Done, Busy, Out);
        end
    endtask

    task automatic test_shifts;
        logic [3:0] ops  [4] = '{4'd4, 4'd5, 4'd5, 4'd4};
        logic       sgns [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] as   [4] = '{8'h81, 8'h90, 8'h90, 8'h81};
        logic [7:0] bs   [4] = '{8'd3, 8'd2, 8'd2, 8'd8};
        logic [7:0] exps [4] = '{8'h08, 8'hE4, 8'h24, 8'h81};
        int         lats [4] = '{3, 2, 2, 0};
        int  edges, busy_n;
        bit  moved, tmo;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], sgns[i], as[i], bs[i], edges, busy_n, moved, tmo);
            n_checks++;
            if (tmo || Out !== exps[i] || edges != lats[i] || busy_n != lats[i]) begin
                n_fail++;
                $display("FAIL shift%0d: got Out=%h edges=%0d busy=%0d timeout=%0b expected %h %0d %0d 0",
                         i, Out, edges, busy_n, tmo, exps[i], lats[i], lats[i]);
            end
        end
    endtask

    task automatic test_compares;
        int  edges, busy_n;
        bit  moved, tmo;
        run_op(4'd7, 1'b1, 8'hFF, 8'h01, edges, busy_n, moved, tmo);
        n_checks++;
        if (tmo || {Out, Zero} !== {8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL slt_signed: got Out=%h Z=%b expected 00 1", Out, Zero);
        end
        run_op(4'd7, 1'b0, 8'hFF, 8'h01, edges, busy_n, moved, tmo);
        n_checks++;
        if (tmo || {Out, Zero} !== {8'h01, 1'b0}) begin
            n_fail++;
            $display("FAIL slt_unsigned: got Out=%h Z=%b expected 01 0", Out, Zero);
        end
        run_op(4'd6, 1'b0, 8'h3C, 8'h3C, edges, busy_n, moved, tmo);
        n_checks++;
        if (tmo || {Out, Zero} !== {8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL seq_equal: got Out=%h Z=%b expected 00 1", Out, Zero);
        end
    endtask

    task automatic test_random;
        logic [7:0] r, a, b;
        logic       c, sgn;
        logic [3:0] op;
        int         lat, edges, busy_n;
        bit         moved, tmo;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom); sgn = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            model(op, sgn, a, b, r, c, lat);
            run_op(op, sgn, a, b, edges, busy_n, moved, tmo);
            n_checks++;
            if (tmo || moved || edges != lat || busy_n != lat || Busy !== 1'b0 ||
                {Out, Zero, Carry, Neg} !== {r, r == 8'h00, c, r[7]}) begin
                n_fail++;
                $display("FAIL random op=%0d s=%b a=%h b=%h: got Out=%h Z=%b C=%b N=%b edges=%0d busy=%0d moved=%0b tmo=%0b expected %h %b %b %b %0d",
                         op, sgn, a, b, Out, Zero, Carry, Neg, edges, busy_n, moved, tmo,
                         r, r == 8'h00, c, r[7], lat);
            end
        end
    endtask

    task automatic test_reset_mid_mul;
        int  edges, busy_n, dones;
        bit  moved, tmo;
        run_op(4'd0, 1'b0, 8'h05, 8'h06, edges, busy_n, moved, tmo);
        Start = 1'b1; OP = 4'd10; InputA = 8'd13; InputB = 8'd11;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        n_checks++;
        if ({Busy, Done, Out, Zero} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid_mul: got B=%b D=%b Out=%h Z=%b expected 0 0 00 1", Busy, Done, Out, Zero);
        end
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(posedge Clk); #1;
            if (Done === 1'b1 || Busy === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL aborted_done: got %0d Done/Busy cycles expected 0", dones);
        end
        run_op(4'd0, 1'b0, 8'h03, 8'h04, edges, busy_n, moved, tmo);
        n_checks++;
        if (tmo || edges != 0 || {Out, Zero, Carry} !== {8'h07, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_after_reset: got Out=%h edges=%0d expected 07 0", Out, edges);
        end
    endtask

    initial begin
        test_reset();
        @(posedge Clk); #1;
        test_back_to_back();
        test_mul();
        test_shifts();
        test_compares();
        test_random();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, clocked successor to the processor's combinational ALU. It registers every result and flag, and adds a start/done handshake. Shifts by a variable amount and multiply run as multi-cycle operations. It sits between the register-file read ports and the writeback mux, and the controller stalls on `Busy`.

## Interface
- `W`, default 8, datapath width in bits (≥4, power of two).
- `OPW`, default 4, opcode width.
- `Clk` in 1, rising-edge clock.
- `Reset_n` in 1. One clock; reset is asynchronous and active-low.
- `Start` in 1, request. Accepted on a rising edge where `Start=1` and `Busy=0`.
- `OP` in OPW, operation. Latched at accept.
- `Signed` in 1, mode. Latched at accept. Selects signed compare for SLT and arithmetic right shift for RSH.
- `InputA` in W, operand A (Rd). Latched at accept.
- `InputB` in W, operand B (Rs or shift amount). Latched at accept.
- `Out` out W, registered result. Holds until the next completion.
- `Zero` out 1, registered: `Out==0`.
- `Carry` out 1, registered carry/borrow.
- `Neg` out 1, registered `Out[W-1]`.
- `Done` out 1, one-cycle pulse. `Out` and the flags are valid and newly updated in this cycle.
- `Busy` out 1, high while a multi-cycle operation runs.

## Operation
- Opcodes:
  - 0 ADD: A+B; `Carry` = carry-out.
  - 1 RXOR: `{W-1 zeros, ^A}`.
  - 2 XOR.
  - 3 AND.
  - 4 LSH: A<<s.
  - 5 RSH: A>>s; arithmetic if `Signed`.
  - 6 SEQ: 0 if A==B, else 1.
  - 7 SLT: 0 if A<B, else 1; signed compare if `Signed`.
  - 8 OR.
  - 9 SUB: A−B mod 2^W; `Carry`=1 on borrow (A<B unsigned).
  - 10 MUL: low W bits of A×B, unsigned.
  - 11–15: `Out`=0.
- Shift amount: s = `InputB[log2(W)-1:0]`. Upper bits are ignored.
- `Carry`=0 for every opcode except ADD and SUB. `Neg` and `Zero` always derive from the new `Out`.
- Single-cycle class: every opcode except LSH/RSH with s≠0, and MUL. LSH/RSH with s=0 is single-cycle and gives `Out`=A.
- State machine:
  - IDLE:
    - Accept of a single-cycle op: on that edge load `Out` and flags, set `Done`=1, remain in IDLE.
    - Accept of LSH/RSH with s≠0: latch A into the work register and s into the counter, set `Busy`=1, go to SHIFT.
    - Accept of MUL: clear the accumulator, latch A (multiplicand) and B (multiplier), load the counter with W, set `Busy`=1, go to MUL.
  - SHIFT: each edge shifts the work register one bit (zero fill; for arithmetic RSH, sign fill) and decrements the counter. On the edge where the counter goes 1→0, load `Out` and flags, set `Done`=1, clear `Busy`, return to IDLE.
  - MUL: each edge does: if multiplier LSB is 1, add the multiplicand to the accumulator (W bits, overflow discarded); shift the multiplicand left 1; shift the multiplier right 1; decrement the counter. On the edge where the counter goes 1→0, load `Out` and flags, set `Done`=1, clear `Busy`, return to IDLE.
- `Done` deasserts on the next edge unless another completion occurs on that edge.
- `Out` and the flags change only on completion edges. Intermediate values are never visible on `Out`.
- `Start` while `Busy`=1 is ignored: no latch, no effect, no queueing.
- `Start` on the completion edge of a multi-cycle op is ignored, because `Busy` is still 1 before that edge.
- Operand or `OP` changes after accept have no effect on an in-flight op.

## Timing
- Reset (asynchronous assert, any time including mid-op):
  - State goes to IDLE.
  - `Out`=0, `Zero`=1, `Carry`=0, `Neg`=0, `Done`=0, `Busy`=0.
  - Counter and work registers are cleared. An aborted op never produces `Done`.
  - Deassertion is synchronous to `Clk` at the system level. The first accept can happen on the first edge after release.
- Single-cycle latency: `Done` is high in the cycle after the accept edge. Throughput is 1 op per cycle with `Start` held high.
- Shift latency: `Done` is high after the accept edge plus s edges. `Busy` is high for s cycles.
- MUL latency: `Done` is high after the accept edge plus W edges. `Busy` is high for W cycles.
- Minimum gap between multi-cycle op completion and the next accept: the next accept is on the edge after `Busy` falls (same cycle as `Done`).
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset values:** hold `Reset_n`=0 → `Out`=0, `Zero`=1, `Carry`=0, `Neg`=0, `Done`=0, `Busy`=0.
- **ADD then SUB, back to back** (W=8):
  - Stimulus: ADD A=8'hF0, B=8'h20; then SUB A=8'h05, B=8'h07 on consecutive edges.
  - Cycle 1: `Out`=8'h10, `Carry`=1, `Done`=1.
  - Cycle 2: `Out`=8'hFE, `Carry`=1, `Neg`=1, `Done`=1.
- **MUL:** A=8'd13, B=8'd11.
  - `Busy`=1 for 8 cycles, with `Out` unchanged meanwhile.
  - Then `Out`=8'h8F, `Neg`=1, `Done` pulse exactly 8 edges after accept.
  - A `Start` with ADD issued mid-op is ignored (no extra `Done`).
- **Shifts:**
  - LSH A=8'h81, B=3 → `Out`=8'h08 after 3 cycles.
  - RSH with `Signed`=1, A=8'h90, B=2 → 8'hE4.
  - RSH with `Signed`=0, same operands → 8'h24.
  - LSH with B=8 (s=0) → `Out`=8'h81 in 1 cycle, `Busy` never high.
- **Compares:**
  - SLT A=8'hFF, B=8'h01: `Signed`=1 → `Out`=0; `Signed`=0 → `Out`=1, `Zero`=0.
  - SEQ A=B=8'h3C → `Out`=0, `Zero`=1.
- **Reset mid-MUL:** assert `Reset_n` at cycle 4 of MUL → immediately `Busy`=0, `Out`=0, `Zero`=1. No `Done` afterwards. A new ADD after release completes normally.
